// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Purpose:
//    Lets NUM_REQ byte producers share one UART transmitter. Requests are
//    granted round-robin. The winner's byte is latched onto uart_din, and one
//    write strobe is issued. The arbiter then follows the UART busy flag until
//    the frame ends, and only after that grants the next requester.
//
// Ports:
//    clk           in   system clock, rising edge
//    reset         in   synchronous active-high reset
//    req           in   [NUM_REQ]        per-requester level request, held until ack
//    req_data      in   [NUM_REQ*DATA_W] packed bytes, requester i at [i*DATA_W +: DATA_W]
//    ack           out  [NUM_REQ]        one-cycle pulse to the winner when its byte is latched
//    tx_done       out  [NUM_REQ]        one-cycle pulse to the granted requester at frame end
//    uart_din      out  [DATA_W]         registered byte to the UART
//    uart_wr_en    out                   one-cycle write strobe to the UART
//    uart_tx_busy  in                    UART transmitter busy flag
//    arb_busy      out                   high whenever the FSM is not idle
//    grant_id      out  [ID_W]           index of the current / last granted requester
//    err           out                   watchdog timeout pulse
//
// Optional feature:
//    UART_ARB_WATCHDOG_EN - when defined, a 13-bit watchdog aborts a grant that
//    waits too long for the UART busy flag. It returns to IDLE and pulses err.
//    When undefined, err is tied low and the wait states wait indefinitely.
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int DATA_W      = 8,
   parameter int ID_W        = 2,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        ack,
   output logic [NUM_REQ-1:0]        tx_done,
   output logic [DATA_W-1:0]         uart_din,
   output logic                      uart_wr_en,
   input  logic                      uart_tx_busy,
   output logic                      arb_busy,
   output logic [ID_W-1:0]           grant_id,
   output logic                      err
);

   // Reject parameter sets the datapath cannot represent (13-bit watchdog, ID width).
   if (NUM_REQ < 2 || NUM_REQ > 8 || ID_W != $clog2(NUM_REQ) ||
       TIMEOUT_CYC < 2 || TIMEOUT_CYC > 8192) begin : g_param_check
      $error("uart_tx_arbiter: illegal parameter combination");
   end

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LAUNCH    = 2'd1,
      ST_WAIT_BUSY = 2'd2,
      ST_WAIT_DONE = 2'd3
   } state_t;

   state_t                state_q,      state_d;
   logic [ID_W-1:0]       last_q,       last_d;
   logic [ID_W-1:0]       grant_id_q,   grant_id_d;
   logic [DATA_W-1:0]     uart_din_q,   uart_din_d;
   logic [NUM_REQ-1:0]    ack_q,        ack_d;
   logic [NUM_REQ-1:0]    tx_done_q,    tx_done_d;
   logic                  uart_wr_en_q, uart_wr_en_d;
   logic                  arb_busy_q,   arb_busy_d;
   logic                  err_q,        err_d;
   logic [ID_W-1:0]       winner;

`ifdef UART_ARB_WATCHDOG_EN
   logic [12:0]           wd_cnt_q,     wd_cnt_d;
`endif

   // First asserted request scanning upward from last+1 with wrap-around.
   function automatic logic [ID_W-1:0] pick_winner(input logic [NUM_REQ-1:0] r,
                                                   input logic [ID_W-1:0]    last);
      logic [ID_W-1:0] win;
      logic            found;
      int              idx;
      win   = last;
      found = 1'b0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = (int'(last) + i) % NUM_REQ;
         if (!found && r[idx]) begin
            win   = ID_W'(idx);
            found = 1'b1;
         end else begin
            win   = win;
            found = found;
         end
      end
      return win;
   endfunction

   // Byte of requester 'id' out of the packed request data.
   function automatic logic [DATA_W-1:0] pick_byte(input logic [NUM_REQ*DATA_W-1:0] data,
                                                   input logic [ID_W-1:0]           id);
      logic [DATA_W-1:0] b;
      b = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (ID_W'(i) == id) begin
            b = data[i*DATA_W +: DATA_W];
         end else begin
            b = b;
         end
      end
      return b;
   endfunction

   // One-hot vector with only bit 'id' set.
   function automatic logic [NUM_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
      logic [NUM_REQ-1:0] v;
      v = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         v[i] = (ID_W'(i) == id);
      end
      return v;
   endfunction

   assign winner = pick_winner(req, last_q);

   // Next-state and next-output logic for the grant FSM.
   always_comb begin
      state_d      = state_q;
      last_d       = last_q;
      grant_id_d   = grant_id_q;
      uart_din_d   = uart_din_q;
      ack_d        = '0;
      tx_done_d    = '0;
      uart_wr_en_d = 1'b0;
      err_d        = 1'b0;
`ifdef UART_ARB_WATCHDOG_EN
      wd_cnt_d     = wd_cnt_q;
`endif

      case (state_q)
         ST_IDLE: begin
            // The strobe and ack are registered on the arbitration edge, so
            // they are high during the LAUNCH cycle.
            if ((|req) && !uart_tx_busy) begin
               state_d      = ST_LAUNCH;
               last_d       = winner;
               grant_id_d   = winner;
               uart_din_d   = pick_byte(req_data, winner);
               ack_d        = id_to_onehot(winner);
               uart_wr_en_d = 1'b1;
            end else begin
               state_d      = ST_IDLE;
            end
         end

         ST_LAUNCH: begin
            state_d = ST_WAIT_BUSY;
`ifdef UART_ARB_WATCHDOG_EN
            wd_cnt_d = 13'd0;
`endif
         end

         ST_WAIT_BUSY: begin
            if (uart_tx_busy) begin
               state_d = ST_WAIT_DONE;
`ifdef UART_ARB_WATCHDOG_EN
               wd_cnt_d = 13'd0;
`endif
            end else begin
`ifdef UART_ARB_WATCHDOG_EN
               wd_cnt_d = wd_cnt_q + 13'd1;
               if (wd_cnt_d == 13'(TIMEOUT_CYC - 1)) begin
                  state_d = ST_IDLE;
                  err_d   = 1'b1;
               end else begin
                  state_d = ST_WAIT_BUSY;
               end
`else
               state_d = ST_WAIT_BUSY;
`endif
            end
         end

         ST_WAIT_DONE: begin
            if (!uart_tx_busy) begin
               state_d   = ST_IDLE;
               tx_done_d = id_to_onehot(grant_id_q);
            end else begin
`ifdef UART_ARB_WATCHDOG_EN
               wd_cnt_d = wd_cnt_q + 13'd1;
               if (wd_cnt_d == 13'(TIMEOUT_CYC - 1)) begin
                  state_d = ST_IDLE;
                  err_d   = 1'b1;
               end else begin
                  state_d = ST_WAIT_DONE;
               end
`else
               state_d = ST_WAIT_DONE;
`endif
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // arb_busy is registered from the next state, so it tracks state_q exactly.
      arb_busy_d = (state_d != ST_IDLE);
   end

   // State and output registers. Reset does not touch a frame already in the UART.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         last_q       <= ID_W'(NUM_REQ - 1);
         grant_id_q   <= '0;
         uart_din_q   <= '0;
         ack_q        <= '0;
         tx_done_q    <= '0;
         uart_wr_en_q <= 1'b0;
         arb_busy_q   <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_q       <= last_d;
         grant_id_q   <= grant_id_d;
         uart_din_q   <= uart_din_d;
         ack_q        <= ack_d;
         tx_done_q    <= tx_done_d;
         uart_wr_en_q <= uart_wr_en_d;
         arb_busy_q   <= arb_busy_d;
         err_q        <= err_d;
      end
   end

`ifdef UART_ARB_WATCHDOG_EN
   // Watchdog counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         wd_cnt_q <= 13'd0;
      end else begin
         wd_cnt_q <= wd_cnt_d;
      end
   end
`endif

   assign ack        = ack_q;
   assign tx_done    = tx_done_q;
   assign uart_din   = uart_din_q;
   assign uart_wr_en = uart_wr_en_q;
   assign arb_busy   = arb_busy_q;
   assign grant_id   = grant_id_q;
   assign err        = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed self-checking bench for uart_tx_arbiter. A small UART stub raises
// tx_busy for five cycles after each write strobe. The stub can be disabled
// (busy stuck low), or busy can be forced high.
// Watchdog checks are compiled only when UART_ARB_WATCHDOG_EN is defined.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

   localparam int NUM_REQ = 4;
   localparam int DATA_W  = 8;
   localparam int ID_W    = 2;
   localparam int TMO     = 16;

   logic                      clk;
   logic                      reset;
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        ack;
   logic [NUM_REQ-1:0]        tx_done;
   logic [DATA_W-1:0]         uart_din;
   logic                      uart_wr_en;
   logic                      uart_tx_busy;
   logic                      arb_busy;
   logic [ID_W-1:0]           grant_id;
   logic                      err;

   // UART stub state
   logic                      stub_en;
   logic                      force_busy;
   logic [7:0]                stub_cnt = 8'd0;
   int                        cyc = 0;
   int                        txd_cnt = 0;
   int                        onehot_viol = 0;

   int                        n_checks = 0;
   int                        n_err    = 0;

   // values returned by wait_wr
   logic [ID_W-1:0]           got_id;
   logic [DATA_W-1:0]         got_din;
   logic [NUM_REQ-1:0]        got_ack;
   int                        got_cyc;

   uart_tx_arbiter #(
      .NUM_REQ     (NUM_REQ),
      .DATA_W      (DATA_W),
      .ID_W        (ID_W),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .req          (req),
      .req_data     (req_data),
      .ack          (ack),
      .tx_done      (tx_done),
      .uart_din     (uart_din),
      .uart_wr_en   (uart_wr_en),
      .uart_tx_busy (uart_tx_busy),
      .arb_busy     (arb_busy),
      .grant_id     (grant_id),
      .err          (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   assign uart_tx_busy = force_busy | (stub_cnt != 8'd0);

   // UART stub: busy for five cycles starting the cycle after a write strobe.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (uart_wr_en && stub_en) begin
         stub_cnt <= 8'd5;
      end else if (stub_cnt != 8'd0) begin
         stub_cnt <= stub_cnt - 8'd1;
      end
   end

   // Monitor: count tx_done pulses and one-hot violations of ack/tx_done.
   always @(negedge clk) begin
      if (|tx_done) begin
         txd_cnt <= txd_cnt + 1;
      end
      if (!$onehot0(ack) || !$onehot0(tx_done) ||
          ((|ack) && (|tx_done) && (ack != tx_done))) begin
         onehot_viol <= onehot_viol + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req   = '0;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Advance until a write strobe is observed (bounded).
   task automatic wait_wr(input string tag);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 200; k++) begin
         tick();
         if (uart_wr_en) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         check({tag, "_timeout"}, 32'd0, 32'd1);
      end
      got_id  = grant_id;
      got_din = uart_din;
      got_ack = ack;
      got_cyc = cyc;
   endtask

   initial begin
      logic [ID_W-1:0]   exp_id [5];
      logic [DATA_W-1:0] exp_dn [5];
      int                prev_cyc;
      int                txd_base;
      int                k;
      bit                fell;

      reset      = 1'b1;
      req        = '0;
      req_data   = '0;
      stub_en    = 1'b1;
      force_busy = 1'b0;
      tick();
      tick();

      // ---- reset state
      check("rst_ack",      32'(ack),        32'd0);
      check("rst_tx_done",  32'(tx_done),    32'd0);
      check("rst_wr_en",    32'(uart_wr_en), 32'd0);
      check("rst_din",      32'(uart_din),   32'd0);
      check("rst_grant",    32'(grant_id),   32'd0);
      check("rst_arb_busy", 32'(arb_busy),   32'd0);
      check("rst_err",      32'(err),        32'd0);
      reset = 1'b0;
      tick();

      // ---- T1: single request, byte A5
      req      = 4'b0001;
      req_data = {8'h00, 8'h00, 8'h00, 8'hA5};
      tick();
      check("t1_wr_en",    32'(uart_wr_en), 32'd1);
      check("t1_ack",      32'(ack),        32'h1);
      check("t1_din",      32'(uart_din),   32'hA5);
      check("t1_grant",    32'(grant_id),   32'd0);
      check("t1_arb_busy", 32'(arb_busy),   32'd1);
      req = 4'b0000;
      tick();
      check("t1_wr_en_1cyc", 32'(uart_wr_en), 32'd0);
      check("t1_ack_1cyc",   32'(ack),        32'd0);
      fell = 1'b0;
      for (k = 0; k < 50; k++) begin
         if (!uart_tx_busy) begin
            fell = 1'b1;
            break;
         end
         tick();
      end
      check("t1_busy_fell", 32'(fell), 32'd1);
      check("t1_no_done_yet", 32'(tx_done), 32'd0);
      tick();
      check("t1_tx_done",  32'(tx_done),  32'h1);
      check("t1_arb_idle", 32'(arb_busy), 32'd0);
      tick();
      check("t1_tx_done_1cyc", 32'(tx_done), 32'd0);

      // ---- T2: all four requesting, round-robin order
      do_reset();
      req_data = {8'h13, 8'h12, 8'h11, 8'h10};
      req      = 4'b1111;
      exp_id   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      exp_dn   = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
      prev_cyc = 0;
      for (int g = 0; g < 5; g++) begin
         wait_wr($sformatf("t2_g%0d", g));
         check($sformatf("t2_grant%0d", g), 32'(got_id),  32'(exp_id[g]));
         check($sformatf("t2_din%0d", g),   32'(got_din), 32'(exp_dn[g]));
         check($sformatf("t2_ack%0d", g),   32'(got_ack), 32'(4'b0001 << exp_id[g]));
         if (g > 0) begin
            // frame of 5 busy cycles plus LAUNCH, WAIT_BUSY, tx_done cycle
            check($sformatf("t2_gap%0d", g), 32'(got_cyc - prev_cyc), 32'd8);
         end
         prev_cyc = got_cyc;
      end

      // ---- T3: grant 2, then 0101 -> 0 (wrap) then 2
      do_reset();
      req = 4'b0100;
      wait_wr("t3_a");
      check("t3_first", 32'(got_id), 32'd2);
      req = 4'b0101;
      wait_wr("t3_b");
      check("t3_wrap",     32'(got_id),  32'd0);
      check("t3_wrap_din", 32'(got_din), 32'h10);
      wait_wr("t3_c");
      check("t3_next",     32'(got_id),  32'd2);
      check("t3_next_din", 32'(got_din), 32'h12);

      // ---- T4: uart busy while idle blocks the grant
      force_busy = 1'b1;
      do_reset();
      req = 4'b0010;
      k = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (uart_wr_en) begin
            k++;
         end
      end
      check("t4_no_wr_while_busy", 32'(k), 32'd0);
      check("t4_idle_while_busy",  32'(arb_busy), 32'd0);
      force_busy = 1'b0;
      tick();
      check("t4_wr_after_busy", 32'(uart_wr_en), 32'd1);
      check("t4_ack",           32'(ack),        32'h2);
      check("t4_grant",         32'(grant_id),   32'd1);

      // ---- T5: reset in WAIT_DONE
      do_reset();
      req = 4'b0001;
      wait_wr("t5_a");
      check("t5_first", 32'(got_id), 32'd0);
      req = 4'b0000;
      tick();
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      txd_base = txd_cnt;
      check("t5_ack",      32'(ack),        32'd0);
      check("t5_tx_done",  32'(tx_done),    32'd0);
      check("t5_wr_en",    32'(uart_wr_en), 32'd0);
      check("t5_din",      32'(uart_din),   32'd0);
      check("t5_grant",    32'(grant_id),   32'd0);
      check("t5_arb_busy", 32'(arb_busy),   32'd0);
      check("t5_err",      32'(err),        32'd0);
      req = 4'b0011;
      wait_wr("t5_b");
      check("t5_req0_wins", 32'(got_id),  32'd0);
      check("t5_din",       32'(got_din), 32'h10);
      check("t5_no_stray_done", 32'(txd_cnt - txd_base), 32'd0);

`ifdef UART_ARB_WATCHDOG_EN
      // ---- T6: busy never rises -> watchdog error
      do_reset();
      stub_en = 1'b0;
      req = 4'b0001;
      wait_wr("t6_a");
      req = 4'b0000;
      txd_base = txd_cnt;
      fell = 1'b0;
      for (k = 1; k <= 40; k++) begin
         tick();
         if (err) begin
            fell = 1'b1;
            break;
         end
      end
      check("t6_err_seen",  32'(fell), 32'd1);
      check("t6_err_delay", 32'(k),    32'd16);
      check("t6_arb_idle",  32'(arb_busy), 32'd0);
      check("t6_grant_kept", 32'(grant_id), 32'd0);
      tick();
      check("t6_err_1cyc", 32'(err), 32'd0);
      check("t6_no_done",  32'(txd_cnt - txd_base), 32'd0);
      stub_en = 1'b1;
      req = 4'b0011;
      wait_wr("t6_b");
      check("t6_next_grant", 32'(got_id), 32'd1);
`endif

      req = '0;
      tick();
      tick();
      check("onehot_ack_done", 32'(onehot_viol), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART transmitter (the parity UART's din/wr_en/tx_busy interface) among NUM_REQ byte producers. It uses round-robin arbitration and latches the winner's byte. It then issues a single-cycle write strobe and tracks the UART's busy flag until the frame completes, before granting the next requester. It sits between the system-side byte sources and the uart core's transmit port.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, byte width; must match uart din
ID_W, 2, width of grant_id; must equal clog2(NUM_REQ)
TIMEOUT_CYC, 4096, watchdog limit in clk cycles (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
req  in  NUM_REQ  per-requester send request; level, held until ack
req_data  in  NUM_REQ*DATA_W  packed bytes; requester i uses bits [i*DATA_W +: DATA_W]
ack  out  NUM_REQ  one-cycle pulse to the winner when its byte is latched
tx_done  out  NUM_REQ  one-cycle pulse to the granted requester when the frame ends
uart_din  out  DATA_W  registered byte to the uart din
uart_wr_en  out  1  one-cycle write strobe to the uart
uart_tx_busy  in  1  uart tx_busy
arb_busy  out  1  high whenever state != IDLE
grant_id  out  ID_W  index of the current/last granted requester
err  out  1  watchdog error pulse (tied 0 without the optional feature)

Behaviour:
- Reset (synchronous, takes effect at the next clk edge, including mid-frame):
  - state=IDLE.
  - ack, tx_done, uart_wr_en, uart_din, grant_id, arb_busy and err all 0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 has highest priority first.
  - The uart is not touched further; any frame in flight completes on its own.
- FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - Arbitrates when |req==1 and uart_tx_busy==0.
  - Winner is the first asserted req scanning from (last+1) mod NUM_REQ upward with wrap.
  - On that edge: latch uart_din<=winner's byte, grant_id<=winner, last<=winner; go to LAUNCH.
  - If uart_tx_busy==1, stay in IDLE; no grant is made.
- LAUNCH (exactly 1 cycle): uart_wr_en=1 and ack[grant_id]=1; go to WAIT_BUSY.
- WAIT_BUSY: stay until uart_tx_busy==1, then go to WAIT_DONE.
- WAIT_DONE:
  - Stay while uart_tx_busy==1.
  - On the first cycle it reads 0: pulse tx_done[grant_id] for 1 cycle and go to IDLE.
- Latency and throughput:
  - req sampled at edge n gives uart_wr_en/ack high during cycle n+1.
  - Back-to-back: next wr_en no earlier than 2 cycles after tx_busy falls.
- Signal rules:
  - uart_din is stable from LAUNCH until the next grant.
  - The requester may drop req or change req_data any time after ack.
  - Dropping req before ack, after the arbitration edge, is ignored; the latched byte is still sent.
  - At most one bit of ack and at most one bit of tx_done is high in any cycle; never both to different ids.
- Simultaneous requests: each requester is served at most once per NUM_REQ grants while others are waiting (no starvation).

Optional Feature:
- Macro: UART_ARB_WATCHDOG_EN.
- When defined:
  - A 13-bit counter clears on entry to WAIT_BUSY/WAIT_DONE and counts every cycle in those states.
  - Reaching TIMEOUT_CYC-1 forces state to IDLE and pulses err for 1 cycle.
  - No tx_done is pulsed; grant_id keeps the faulty id; last still advances.
- When undefined:
  - No counter; err is tied 0.
  - WAIT_BUSY/WAIT_DONE wait indefinitely.

Test Plan:
1. After reset, req=4'b0001 with byte 8'hA5 -> ack[0] and uart_wr_en high for exactly 1 cycle, 1 cycle after req; uart_din=8'hA5; tx_done[0] 1 cycle after tx_busy falls; arb_busy low afterward.
2. req=4'b1111 held with bytes 8'h10,8'h11,8'h12,8'h13 -> UART receives 10,11,12,13 in that order; then 10 again if req[0] is still set; grant_id goes 0,1,2,3,0.
3. After grant 2, req=4'b0101 -> next grant is 0 (wrap past 3), then 2; no requester granted twice consecutively while another waits.
4. Hold uart_tx_busy=1 while in IDLE with req=4'b0010 -> no wr_en until busy drops; wr_en one cycle after busy low.
5. Assert reset for 1 cycle during WAIT_DONE -> next cycle all outputs 0, state IDLE; the following request from req[0] wins even if last grant was 0.
6. With UART_ARB_WATCHDOG_EN and TIMEOUT_CYC=16, stub tx_busy stuck at 0 after wr_en -> err pulses 1 cycle, 16 cycles after LAUNCH; no tx_done; arbiter serves the next request normally.
